sa_inst_sequencer: RTL and testbench

//  Program-driven instruction sequencer for the systolic array top (SYSTOLIC_ARRAY_AXI4_FULL).
//  - A host loads a small program table; each entry expands into COUNT instructions.
//  - Instruction k of an entry carries addresses base+k*stride.
//  - Instructions are issued over the existing instruction/flag handshake.
//  - Replaces hand-written issue loops (AXI_TO_UB, UB_TO_DATA_FIFO, MAT_MUL, UB_TO_AXI ...).

---
 rtl/sa_inst_sequencer.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_sa_inst_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_inst_sequencer.sv
// -----------------------------------------------------------------------------
// sa_inst_sequencer
//
// Program-driven instruction sequencer for the systolic array top.
// A host loads a small program table. Each table entry expands into COUNT
// instructions, and instruction k of an entry carries the addresses
// base + k*stride. Instructions go to the array over the existing
// instruction/flag handshake. One flag high->low slot consumes one
// instruction.
//
// Optional feature macro: SA_SEQ_IDLE_SYNC_EN
//   When defined, the sequencer stalls in S_WAIT_BUSY after the first
//   instruction of every entry is consumed. It stays there until idle_flag
//   drops, which shows that the array has accepted the work. When undefined,
//   idle_flag is ignored.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   prog_wen     program table write strobe (ignored while busy)
//   prog_waddr   program table entry index
//   prog_wdata   {OPCODE, ADDRA_BASE, ADDRB_BASE, STRIDE_A, STRIDE_B, COUNT}
//   start        1-cycle pulse: run the program from entry 0
//   abort        1-cycle pulse: stop after the in-flight instruction
//   flag         array slot strobe; high then low = slot consumed
//   idle_flag    array idle indicator (SA_SEQ_IDLE_SYNC_EN only)
//   instruction  registered {OPCODE, ADDRA, ADDRB} to the array
//   busy         high from accepted start until done
//   done         1-cycle completion pulse
//   issued_cnt   instructions consumed since last start (saturating)
// -----------------------------------------------------------------------------
module sa_inst_sequencer #(
    parameter int OPCODE_BITS = 4,
    parameter int ADDR_BITS   = 16,
    parameter int STRIDE_BITS = 8,
    parameter int CNT_BITS    = 8,
    parameter int DEPTH       = 16,
    parameter int IDLE_OPCODE = 0,
    localparam int ENTRY_W    = OPCODE_BITS + 2*ADDR_BITS + 2*STRIDE_BITS + CNT_BITS,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int INSTR_W    = OPCODE_BITS + 2*ADDR_BITS
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               prog_wen,
    input  logic [PTR_W-1:0]   prog_waddr,
    input  logic [ENTRY_W-1:0] prog_wdata,
    input  logic               start,
    input  logic               abort,
    input  logic               flag,
    input  logic               idle_flag,
    output logic [INSTR_W-1:0] instruction,
    output logic               busy,
    output logic               done,
    output logic [15:0]        issued_cnt
);

    localparam logic [INSTR_W-1:0] IDLE_INSTR =
        {OPCODE_BITS'(IDLE_OPCODE), {(2*ADDR_BITS){1'b0}}};

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
`ifdef SA_SEQ_IDLE_SYNC_EN
        S_WAIT_BUSY,
`endif
        S_DRAIN_HI,
        S_DRAIN_LO,
        S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [CNT_BITS-1:0]    k_q, k_d;
    logic [CNT_BITS-1:0]    count_q, count_d;
    logic [OPCODE_BITS-1:0] opcode_q, opcode_d;
    logic [ADDR_BITS-1:0]   acc_a_q, acc_a_d;
    logic [ADDR_BITS-1:0]   acc_b_q, acc_b_d;
    logic [STRIDE_BITS-1:0] stride_a_q, stride_a_d;
    logic [STRIDE_BITS-1:0] stride_b_q, stride_b_d;
    logic                   abort_pend_q, abort_pend_d;
    logic [INSTR_W-1:0]     instruction_q, instruction_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [15:0]            issued_cnt_q, issued_cnt_d;

    logic [ENTRY_W-1:0]     table_mem [DEPTH];
    logic [ENTRY_W-1:0]     fetch_entry;
    logic                   abort_seen;
    logic [CNT_BITS-1:0]    dec_k;
    state_e                 dec_state;
    logic [PTR_W-1:0]       dec_ptr;

`ifndef SA_SEQ_IDLE_SYNC_EN
    logic unused_idle_flag;
    assign unused_idle_flag = idle_flag;
`endif

    // Program table: plain storage with no reset. Host writes are locked out
    // while a program runs, so the running program can never be altered.
    always_ff @(posedge clk) begin
        if (prog_wen && !busy_q) begin
            table_mem[prog_waddr] <= prog_wdata;
        end
    end

    assign fetch_entry = table_mem[ptr_q];

    // Decision taken after an instruction is consumed. It is shared by
    // S_WAIT_LO and S_WAIT_BUSY. In S_WAIT_LO, k has not been bumped yet,
    // so the decision looks one step ahead. An abort that arrives in the
    // same cycle as the decision still takes effect.
    always_comb begin
        abort_seen = abort_pend_q | abort;
        dec_k      = (state_q == S_WAIT_LO) ? (k_q + CNT_BITS'(1)) : k_q;
        dec_ptr    = ptr_q;
        if (abort_seen) begin
            dec_state = S_DRAIN_HI;
        end else if (dec_k < count_q) begin
            dec_state = S_ISSUE;
        end else if (ptr_q == PTR_W'(DEPTH - 1)) begin
            dec_state = S_DRAIN_HI;
        end else begin
            dec_state = S_FETCH;
            dec_ptr   = ptr_q + PTR_W'(1);
        end
    end

    // Main sequencing FSM next-state logic. All outputs are registered.
    // The instruction register changes only in S_ISSUE and on entry to the
    // drain slot. The address accumulators advance by one stride per
    // consumed instruction, which avoids a multiplier.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        k_d           = k_q;
        count_d       = count_q;
        opcode_d      = opcode_q;
        acc_a_d       = acc_a_q;
        acc_b_d       = acc_b_q;
        stride_a_d    = stride_a_q;
        stride_b_d    = stride_b_q;
        abort_pend_d  = abort_pend_q;
        instruction_d = instruction_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        issued_cnt_d  = issued_cnt_q;

        if (state_q != S_IDLE && abort) begin
            abort_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_FETCH;
                    ptr_d        = '0;
                    k_d          = '0;
                    issued_cnt_d = '0;
                    busy_d       = 1'b1;
                    abort_pend_d = 1'b0;
                end
            end
            S_FETCH: begin
                opcode_d   = fetch_entry[ENTRY_W-1 -: OPCODE_BITS];
                acc_a_d    = fetch_entry[CNT_BITS+2*STRIDE_BITS+ADDR_BITS +: ADDR_BITS];
                acc_b_d    = fetch_entry[CNT_BITS+2*STRIDE_BITS +: ADDR_BITS];
                stride_a_d = fetch_entry[CNT_BITS+STRIDE_BITS +: STRIDE_BITS];
                stride_b_d = fetch_entry[CNT_BITS +: STRIDE_BITS];
                count_d    = fetch_entry[CNT_BITS-1:0];
                k_d        = '0;
                if (abort_seen || fetch_entry[CNT_BITS-1:0] == '0) begin
                    state_d       = S_DRAIN_HI;
                    instruction_d = IDLE_INSTR;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                instruction_d = {opcode_q, acc_a_q, acc_b_q};
                state_d       = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (flag) begin
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!flag) begin
                    if (issued_cnt_q != 16'hFFFF) begin
                        issued_cnt_d = issued_cnt_q + 16'd1;
                    end
                    k_d     = k_q + CNT_BITS'(1);
                    acc_a_d = acc_a_q + ADDR_BITS'(stride_a_q);
                    acc_b_d = acc_b_q + ADDR_BITS'(stride_b_q);
`ifdef SA_SEQ_IDLE_SYNC_EN
                    if (k_q == '0) begin
                        state_d = S_WAIT_BUSY;
                    end else begin
                        state_d = dec_state;
                        ptr_d   = dec_ptr;
                        if (dec_state == S_DRAIN_HI) begin
                            instruction_d = IDLE_INSTR;
                        end
                    end
`else
                    state_d = dec_state;
                    ptr_d   = dec_ptr;
                    if (dec_state == S_DRAIN_HI) begin
                        instruction_d = IDLE_INSTR;
                    end
`endif
                end
            end
`ifdef SA_SEQ_IDLE_SYNC_EN
            S_WAIT_BUSY: begin
                if (!idle_flag) begin
                    state_d = dec_state;
                    ptr_d   = dec_ptr;
                    if (dec_state == S_DRAIN_HI) begin
                        instruction_d = IDLE_INSTR;
                    end
                end
            end
`endif
            S_DRAIN_HI: begin
                if (flag) begin
                    state_d = S_DRAIN_LO;
                end
            end
            S_DRAIN_LO: begin
                if (!flag) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            k_q           <= '0;
            count_q       <= '0;
            opcode_q      <= '0;
            acc_a_q       <= '0;
            acc_b_q       <= '0;
            stride_a_q    <= '0;
            stride_b_q    <= '0;
            abort_pend_q  <= 1'b0;
            instruction_q <= IDLE_INSTR;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            issued_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            k_q           <= k_d;
            count_q       <= count_d;
            opcode_q      <= opcode_d;
            acc_a_q       <= acc_a_d;
            acc_b_q       <= acc_b_d;
            stride_a_q    <= stride_a_d;
            stride_b_q    <= stride_b_d;
            abort_pend_q  <= abort_pend_d;
            instruction_q <= instruction_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            issued_cnt_q  <= issued_cnt_d;
        end
    end

    assign instruction = instruction_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign issued_cnt  = issued_cnt_q;

endmodule

// File: tb/tb_sa_inst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sa_inst_sequencer
//
// Directed bench for sa_inst_sequencer with the default parameters.
// Inputs are driven just after a falling edge. Outputs are sampled on the
// falling edge, half a cycle away from the active rising edge. The bench acts
// as the array: it grants one flag high->low slot per instruction. Expected
// instructions and timing are worked out by hand from the program contents.
// -----------------------------------------------------------------------------
module tb_sa_inst_sequencer;

    localparam int ENTRY_W = 60;
    localparam int INSTR_W = 36;

`ifdef SA_SEQ_IDLE_SYNC_EN
    localparam int SX = 1;
`else
    localparam int SX = 0;
`endif

    localparam logic [3:0] AXI_TO_UB = 4'h1;
    localparam logic [3:0] MAT_MUL   = 4'h3;
    localparam logic [3:0] ACC_TO_UB = 4'h4;
    localparam logic [3:0] UB_TO_AXI = 4'h5;
    localparam logic [3:0] LOAD_OP   = 4'h2;

    logic               clk;
    logic               reset_n;
    logic               prog_wen;
    logic [3:0]         prog_waddr;
    logic [ENTRY_W-1:0] prog_wdata;
    logic               start;
    logic               abort;
    logic               flag;
    logic               idle_flag;
    logic [INSTR_W-1:0] instruction;
    logic               busy;
    logic               done;
    logic [15:0]        issued_cnt;

    int nChecks = 0;
    int nErrors = 0;

    sa_inst_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .prog_wen   (prog_wen),
        .prog_waddr (prog_waddr),
        .prog_wdata (prog_wdata),
        .start      (start),
        .abort      (abort),
        .flag       (flag),
        .idle_flag  (idle_flag),
        .instruction(instruction),
        .busy       (busy),
        .done       (done),
        .issued_cnt (issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [ENTRY_W-1:0] mkEntry(input logic [3:0] op,
                                                   input logic [15:0] aa,
                                                   input logic [15:0] ab,
                                                   input logic [7:0] sa,
                                                   input logic [7:0] sb,
                                                   input logic [7:0] cnt);
        return {op, aa, ab, sa, sb, cnt};
    endfunction

    function automatic logic [INSTR_W-1:0] mkInstr(input logic [3:0] op,
                                                   input logic [15:0] a,
                                                   input logic [15:0] b);
        return {op, a, b};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic writeEntry(input logic [3:0] idx, input logic [ENTRY_W-1:0] data);
        prog_wen   = 1'b1;
        prog_waddr = idx;
        prog_wdata = data;
        @(negedge clk);
        prog_wen   = 1'b0;
    endtask

    // Pulse start (optionally with abort) and wait until the first
    // instruction is due: FETCH, ISSUE, then the registered output.
    task automatic applyStimulus(input logic withAbort);
        start = 1'b1;
        abort = withAbort;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checkOutput("busy_after_start", 64'(busy), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    // Check the pending instruction, grant one slot, then wait gap falls.
    task automatic doSlot(input string tag, input logic [INSTR_W-1:0] exp, input int gap);
        checkOutput(tag, 64'(instruction), 64'(exp));
        flag = 1'b1;
        @(negedge clk);
        flag = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Expect the idle flush slot, then the done pulse.
    task automatic doDrain(input string tag, input logic [15:0] expCnt);
        checkOutput({tag, "_idle_instr"}, 64'(instruction), 64'(mkInstr(4'h0, 16'h0, 16'h0)));
        checkOutput({tag, "_busy_drain"}, 64'(busy), 64'd1);
        flag = 1'b1;
        @(negedge clk);
        flag = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_done"}, 64'(done), 64'd1);
        checkOutput({tag, "_busy_end"}, 64'(busy), 64'd0);
        checkOutput({tag, "_issued"}, 64'(issued_cnt), 64'(expCnt));
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        prog_wen   = 1'b0;
        prog_waddr = '0;
        prog_wdata = '0;
        start      = 1'b0;
        abort      = 1'b0;
        flag       = 1'b0;
        idle_flag  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_instr", 64'(instruction), 64'(mkInstr(4'h0, 16'h0, 16'h0)));
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_issued", 64'(issued_cnt), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Test 1: one entry of 16, ADDRB stride 16
        $display("[TB] test 1: single entry");
        writeEntry(4'd0, mkEntry(AXI_TO_UB, 16'd0, 16'd0, 8'd1, 8'd16, 8'd16));
        writeEntry(4'd1, mkEntry(4'h0, 16'd0, 16'd0, 8'd0, 8'd0, 8'd0));
        applyStimulus(1'b0);
        for (int i = 0; i < 16; i++) begin
            doSlot($sformatf("t1_slot%0d", i),
                   mkInstr(AXI_TO_UB, 16'(i), 16'(i * 16)), 2 + ((i == 0) ? SX : 0));
        end
        doDrain("t1", 16'd16);

        // Test 2: two chained entries
        $display("[TB] test 2: two entries");
        writeEntry(4'd0, mkEntry(ACC_TO_UB, 16'd64, 16'd0, 8'd1, 8'd1, 8'd16));
        writeEntry(4'd1, mkEntry(UB_TO_AXI, 16'd0, 16'd64, 8'd4, 8'd1, 8'd16));
        writeEntry(4'd2, mkEntry(4'h0, 16'd0, 16'd0, 8'd0, 8'd0, 8'd0));
        applyStimulus(1'b0);
        for (int i = 0; i < 16; i++) begin
            doSlot($sformatf("t2a_slot%0d", i), mkInstr(ACC_TO_UB, 16'(64 + i), 16'(i)),
                   ((i == 15) ? 3 : 2) + ((i == 0) ? SX : 0));
        end
        for (int i = 0; i < 16; i++) begin
            doSlot($sformatf("t2b_slot%0d", i), mkInstr(UB_TO_AXI, 16'(4 * i), 16'(64 + i)),
                   2 + ((i == 0) ? SX : 0));
        end
        doDrain("t2", 16'd32);

        // Test 3: address wrap; start and abort together, start wins
        $display("[TB] test 3: address wrap");
        writeEntry(4'd0, mkEntry(MAT_MUL, 16'hFFFE, 16'h0010, 8'd1, 8'd2, 8'd4));
        writeEntry(4'd1, mkEntry(4'h0, 16'd0, 16'd0, 8'd0, 8'd0, 8'd0));
        applyStimulus(1'b1);
        doSlot("t3_slot0", mkInstr(MAT_MUL, 16'hFFFE, 16'h0010), 2 + SX);
        doSlot("t3_slot1", mkInstr(MAT_MUL, 16'hFFFF, 16'h0012), 2);
        doSlot("t3_slot2", mkInstr(MAT_MUL, 16'h0000, 16'h0014), 2);
        doSlot("t3_slot3", mkInstr(MAT_MUL, 16'h0001, 16'h0016), 2);
        doDrain("t3", 16'd4);

        // Test 4: abort while the third instruction waits for flag
        $display("[TB] test 4: abort");
        writeEntry(4'd0, mkEntry(AXI_TO_UB, 16'h0100, 16'h0200, 8'd2, 8'd3, 8'd16));
        applyStimulus(1'b0);
        doSlot("t4_slot0", mkInstr(AXI_TO_UB, 16'h0100, 16'h0200), 2 + SX);
        doSlot("t4_slot1", mkInstr(AXI_TO_UB, 16'h0102, 16'h0203), 2);
        checkOutput("t4_slot2", 64'(instruction), 64'(mkInstr(AXI_TO_UB, 16'h0104, 16'h0206)));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("t4_slot2_held", 64'(instruction), 64'(mkInstr(AXI_TO_UB, 16'h0104, 16'h0206)));
        flag = 1'b1;
        @(negedge clk);
        flag = 1'b0;
        repeat (2) @(negedge clk);
        doDrain("t4", 16'd3);

        // Test 5: full table, no terminator; a write while busy is dropped
        $display("[TB] test 5: full table");
        for (int i = 0; i < 16; i++) begin
            writeEntry(4'(i), mkEntry(LOAD_OP, 16'(i), 16'(16'h1000 + i), 8'd0, 8'd0, 8'd1));
        end
        applyStimulus(1'b0);
        writeEntry(4'd5, mkEntry(4'hF, 16'hDEAD, 16'hBEEF, 8'd0, 8'd0, 8'd1));
        for (int i = 0; i < 16; i++) begin
            doSlot($sformatf("t5_slot%0d", i), mkInstr(LOAD_OP, 16'(i), 16'(16'h1000 + i)),
                   ((i == 15) ? 2 : 3) + SX);
        end
        doDrain("t5", 16'd16);

`ifdef SA_SEQ_IDLE_SYNC_EN
        // Stall after first consume while the array reports idle
        $display("[TB] test sync: idle stall");
        writeEntry(4'd0, mkEntry(MAT_MUL, 16'h0010, 16'h0020, 8'd1, 8'd1, 8'd2));
        writeEntry(4'd1, mkEntry(4'h0, 16'd0, 16'd0, 8'd0, 8'd0, 8'd0));
        idle_flag = 1'b1;
        applyStimulus(1'b0);
        doSlot("ts_slot0", mkInstr(MAT_MUL, 16'h0010, 16'h0020), 6);
        checkOutput("ts_stalled_instr", 64'(instruction), 64'(mkInstr(MAT_MUL, 16'h0010, 16'h0020)));
        checkOutput("ts_stalled_busy", 64'(busy), 64'd1);
        idle_flag = 1'b0;
        repeat (2) @(negedge clk);
        doSlot("ts_slot1", mkInstr(MAT_MUL, 16'h0011, 16'h0021), 2);
        doDrain("ts", 16'd2);
`endif

        // Test 6: reset in the middle of S_WAIT_LO
        $display("[TB] test 6: reset mid-run");
        applyStimulus(1'b0);
        checkOutput("t6_first", 64'(instruction), 64'(mkInstr(LOAD_OP, 16'h0000, 16'h1000)));
        flag = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("t6_rst_instr", 64'(instruction), 64'(mkInstr(4'h0, 16'h0, 16'h0)));
        checkOutput("t6_rst_busy", 64'(busy), 64'd0);
        checkOutput("t6_rst_issued", 64'(issued_cnt), 64'd0);
        @(negedge clk);
        flag    = 1'b0;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("t6_post_busy", 64'(busy), 64'd0);
        checkOutput("t6_post_done", 64'(done), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
